demux1to4_32_buf: RTL

- Write-direction counterpart of the 4-way 32-bit read-data selector: takes one 32-bit write stream and delivers each word to exactly one of four destination ports selected by a 2-bit code.
- One-entry registered output stage with valid/ready handshakes on both sides.
- Per-port enable mask and saturating per-port delivery counters for debug and status readback.
- Sits between the CPU data-bus write path and the four peripheral/memory write ports.

---
 rtl/demux1to4_32_buf.sv | 101 ++++++++++
 1 files changed

// File: rtl/demux1to4_32_buf.sv
// One-entry registered 1-to-4 write demux with valid/ready handshakes on both sides,
// a per-port enable mask and saturating per-port delivery counters.

module demux1to4_32_buf_cnt #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt
);
    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != {CW{1'b1}}))
            cnt <= cnt + 1'b1;
    end
endmodule

module demux1to4_32_buf #(
    parameter int DW = 32,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [1:0]    in_sel,
    input  logic [3:0]    port_en,
    output logic [DW-1:0] out_data,
    output logic [3:0]    out_valid,
    input  logic [3:0]    out_ready,
    output logic          drop,
    input  logic          cnt_clr,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1,
    output logic [CW-1:0] cnt2,
    output logic [CW-1:0] cnt3
);
    localparam int NUM_PORTS = 4;

    logic                          full;
    logic [1:0]                    sel_q;
    logic [DW-1:0]                 data_q;
    logic                          drop_q;
    logic                          deliver;
    logic                          accept;
    logic                          acc_load;
    logic                          acc_drop;
    logic [NUM_PORTS-1:0][CW-1:0]  cnt_w;

    // Ready passes straight through from the selected port so a held word
    // and a new word can swap in the same cycle.
    assign deliver  = full && out_ready[sel_q];
    assign in_ready = !full || out_ready[sel_q];
    assign accept   = in_valid && in_ready;
    assign acc_load = accept && port_en[in_sel];
    assign acc_drop = accept && !port_en[in_sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full   <= 1'b0;
            sel_q  <= 2'd0;
            data_q <= '0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= acc_drop;
            if (acc_load) begin
                full   <= 1'b1;
                sel_q  <= in_sel;
                data_q <= in_data;
            end else if (deliver) begin
                full   <= 1'b0;
            end
        end
    end

    assign out_data  = data_q;
    assign out_valid = full ? (4'b0001 << sel_q) : 4'b0000;
    assign drop      = drop_q;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt
        demux1to4_32_buf_cnt #(.CW(CW)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (deliver && (sel_q == 2'(i))),
            .clr   (cnt_clr),
            .cnt   (cnt_w[i])
        );
    end

    assign cnt0 = cnt_w[0];
    assign cnt1 = cnt_w[1];
    assign cnt2 = cnt_w[2];
    assign cnt3 = cnt_w[3];
endmodule
